vga_plot_arbiter: RTL and testbench

Shares the single VGA adapter plot port between the character eraser and the character drawer. Each requester hands over a sprite job (origin plus colour). The arbiter grants one job at a time and sweeps the sprite box one pixel per clock. It drives the adapter's x, y, colour and plot signals, then pulses a done back to the requester. It sits between CharacterFSM's erase/draw producers and the VGA adapter, so two drivers never contend on the adapter inputs.

---
 rtl/vga_plot_arbiter.sv | 134 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA adapter plot port: grants erase/draw sprite jobs one at a
// time, sweeps the sprite box one pixel per clock (clipping off-screen pixels), then pulses done.
module vga_plot_arbiter #(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               erase_req,
  input  logic [X_W-1:0]     erase_x,
  input  logic [Y_W-1:0]     erase_y,
  input  logic [COLOR_W-1:0] erase_color,
  input  logic               draw_req,
  input  logic [X_W-1:0]     draw_x,
  input  logic [Y_W-1:0]     draw_y,
  input  logic [COLOR_W-1:0] draw_color,
  output logic               erase_done,
  output logic               draw_done,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               busy
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [X_W-1:0]       job_x;
  logic [Y_W-1:0]       job_y;
  logic [COLOR_W-1:0]   job_color;
  logic                 owner_draw;
  logic                 last_draw;
  logic                 grant;
  logic                 grant_draw;
  logic                 col_last;
  logic                 last_px;
  logic [X_W:0]         sum_x;
  logic [Y_W:0]         sum_y;

  assign col_last = (col == CW'(SPRITE_W - 1));
  assign last_px  = col_last && (row == RW'(SPRITE_H - 1));
  // One extra bit so an origin near the top of the coordinate range clips instead of wrapping.
  assign sum_x    = {1'b0, job_x} + (X_W+1)'(col);
  assign sum_y    = {1'b0, job_y} + (Y_W+1)'(row);

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_draw = 1'b0;
    case (state)
      IDLE: begin
        if (erase_req && draw_req) begin
          grant      = 1'b1;
          grant_draw = !last_draw;
        end else if (erase_req) begin
          grant      = 1'b1;
        end else if (draw_req) begin
          grant      = 1'b1;
          grant_draw = 1'b1;
        end
        if (grant) state_nx = SWEEP;
      end
      SWEEP:   if (last_px) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      col        <= '0;
      row        <= '0;
      job_x      <= '0;
      job_y      <= '0;
      job_color  <= '0;
      owner_draw <= 1'b0;
      last_draw  <= 1'b1;
    end else if (grant) begin
      col        <= '0;
      row        <= '0;
      job_x      <= grant_draw ? draw_x : erase_x;
      job_y      <= grant_draw ? draw_y : erase_y;
      job_color  <= grant_draw ? draw_color : erase_color;
      owner_draw <= grant_draw;
      last_draw  <= grant_draw;
    end else if (state == SWEEP) begin
      if (col_last) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Outputs trail the state by one clock: pixel n appears n+1 edges after grant, done after 17.
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_color  <= '0;
      vga_plot   <= 1'b0;
      erase_done <= 1'b0;
      draw_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vga_plot   <= (state == SWEEP) && (sum_x < (X_W+1)'(SCREEN_W))
                                     && (sum_y < (Y_W+1)'(SCREEN_H));
      vga_x      <= (state == SWEEP) ? sum_x[X_W-1:0] : '0;
      vga_y      <= (state == SWEEP) ? sum_y[Y_W-1:0] : '0;
      vga_color  <= (state == SWEEP) ? job_color : '0;
      erase_done <= (state == DONE) && !owner_draw;
      draw_done  <= (state == DONE) && owner_draw;
      busy       <= grant || (state != IDLE);
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed and random sprite jobs against a raster-list model.
module tb_vga_plot_arbiter;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int SW  = 4;
  localparam int SH  = 4;

  logic           CLOCK_50 = 1'b0;
  logic           Reset;
  logic           erase_req, draw_req;
  logic [X_W-1:0] erase_x, draw_x;
  logic [Y_W-1:0] erase_y, draw_y;
  logic [C_W-1:0] erase_color, draw_color;
  logic           erase_done, draw_done, vga_plot, busy;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_color;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_plot_arbiter dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset),
    .erase_req(erase_req), .erase_x(erase_x), .erase_y(erase_y), .erase_color(erase_color),
    .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color),
    .erase_done(erase_done), .draw_done(draw_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot), .busy(busy)
  );

  typedef struct packed {
    logic [15:0]    cyc;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pix_t;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   e_done_q[$];
  int   d_done_q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   dual_done = 0;
  int   stray_plot = 0;

  always @(posedge CLOCK_50) cyc++;

  always @(negedge CLOCK_50) begin
    if (vga_plot) got_q.push_back(pix_t'{16'(cyc), vga_x, vga_y, vga_color});
    if (vga_plot && !busy) stray_plot++;
    if (erase_done) e_done_q.push_back(cyc);
    if (draw_done) d_done_q.push_back(cyc);
    if (erase_done && draw_done) dual_done++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLOCK_50);
    #1;
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Every on-screen pixel of the box, raster order; pixel n lands n+1 edges after the grant edge.
  task automatic model_job(input int g, input int x, input int y, input int c);
    for (int r = 0; r < SH; r++)
      for (int k = 0; k < SW; k++) begin
        int sx = x + k;
        int sy = y + r;
        if (sx < 160 && sy < 120)
          exp_q.push_back(pix_t'{16'(g + 1 + r * SW + k), X_W'(sx), Y_W'(sy), C_W'(c)});
      end
  endtask

  task automatic compare_plots(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    e_done_q.delete();
    d_done_q.delete();
  endtask

  task automatic wait_dones(input int n, input int limit);
    int k = 0;
    while (e_done_q.size() + d_done_q.size() < n && k < limit) begin
      step();
      k++;
    end
    chk("done_wait", 64'(e_done_q.size() + d_done_q.size() >= n), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_x"}, 64'(vga_x), 64'd0);
    chk({tag, "_y"}, 64'(vga_y), 64'd0);
    chk({tag, "_color"}, 64'(vga_color), 64'd0);
    chk({tag, "_plot"}, 64'(vga_plot), 64'd0);
    chk({tag, "_done"}, 64'({erase_done, draw_done}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_single(input string tag, input bit is_draw, input int x, input int y,
                            input int c);
    int g;
    if (is_draw) begin
      draw_x = X_W'(x); draw_y = Y_W'(y); draw_color = C_W'(c); draw_req = 1'b1;
    end else begin
      erase_x = X_W'(x); erase_y = Y_W'(y); erase_color = C_W'(c); erase_req = 1'b1;
    end
    g = cyc + 1;
    model_job(g, x, y, c);
    wait_dones(1, 40);
    erase_req = 1'b0;
    draw_req  = 1'b0;
    repeat (2) step();
    if (is_draw) begin
      chk({tag, "_done_cyc"}, 64'(q_at(d_done_q, 0)), 64'(g + 17));
      chk({tag, "_done_n"}, 64'(d_done_q.size()), 64'd1);
    end else begin
      chk({tag, "_done_cyc"}, 64'(q_at(e_done_q, 0)), 64'(g + 17));
      chk({tag, "_done_n"}, 64'(e_done_q.size()), 64'd1);
    end
    compare_plots(tag);
  endtask

  initial begin
    int g;
    int ex, ey, ec, dx, dy, dc;
    Reset = 1'b0;
    erase_req = 1'b0; draw_req = 1'b0;
    erase_x = '0; erase_y = '0; erase_color = '0;
    draw_x = '0; draw_y = '0; draw_color = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    Reset = 1'b1;
    repeat (2) step();

    // Reset mid-sweep: five pixels out, then abandon.
    erase_x = 8'd10; erase_y = 7'd10; erase_color = 3'd2; erase_req = 1'b1;
    repeat (6) step();
    chk("mid_plots", 64'(got_q.size()), 64'd5);
    Reset = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    erase_req = 1'b0;
    got_q.delete();
    e_done_q.delete();
    repeat (2) step();
    Reset = 1'b1;
    repeat (20) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_no_done", 64'(e_done_q.size() + d_done_q.size()), 64'd0);
    chk("rst_no_plot", 64'(got_q.size()), 64'd0);

    // Simultaneous requests right after reset: erase wins, draw follows after one idle cycle.
    ex = $urandom_range(0, 150); ey = $urandom_range(0, 110); ec = $urandom_range(0, 7);
    dx = $urandom_range(0, 150); dy = $urandom_range(0, 110); dc = $urandom_range(0, 7);
    erase_x = X_W'(ex); erase_y = Y_W'(ey); erase_color = C_W'(ec);
    draw_x = X_W'(dx); draw_y = Y_W'(dy); draw_color = C_W'(dc);
    erase_req = 1'b1; draw_req = 1'b1;
    g = cyc + 1;
    model_job(g, ex, ey, ec);
    model_job(g + 18, dx, dy, dc);
    wait_dones(1, 40);
    erase_req = 1'b0;
    wait_dones(2, 40);
    draw_req = 1'b0;
    repeat (2) step();
    chk("tie_erase_cyc", 64'(q_at(e_done_q, 0)), 64'(g + 17));
    chk("tie_draw_cyc", 64'(q_at(d_done_q, 0)), 64'(g + 35));
    chk("tie_done_n", 64'({e_done_q.size(), d_done_q.size()}), {32'd1, 32'd1});
    compare_plots("tie");

    // Both held: E,D,E,D, each 18 cycles apart.
    erase_req = 1'b1; draw_req = 1'b1;
    g = cyc + 1;
    model_job(g, ex, ey, ec);
    model_job(g + 18, dx, dy, dc);
    model_job(g + 36, ex, ey, ec);
    model_job(g + 54, dx, dy, dc);
    wait_dones(4, 120);
    erase_req = 1'b0; draw_req = 1'b0;
    repeat (2) step();
    chk("rr_e0", 64'(q_at(e_done_q, 0)), 64'(g + 17));
    chk("rr_d0", 64'(q_at(d_done_q, 0)), 64'(g + 35));
    chk("rr_e1", 64'(q_at(e_done_q, 1)), 64'(g + 53));
    chk("rr_d1", 64'(q_at(d_done_q, 1)), 64'(g + 71));
    chk("rr_done_n", 64'({e_done_q.size(), d_done_q.size()}), {32'd2, 32'd2});
    compare_plots("rr");

    run_single("erase_20_30", 1'b0, 20, 30, 0);
    run_single("draw_corner", 1'b1, 158, 118, 5);

    // Inputs change and request drops mid-sweep: latched job still completes.
    draw_x = 8'd40; draw_y = 7'd50; draw_color = 3'd3; draw_req = 1'b1;
    g = cyc + 1;
    model_job(g, 40, 50, 3);
    repeat (5) step();
    draw_x = 8'd90; draw_y = 7'd5; draw_color = 3'd6; draw_req = 1'b0;
    wait_dones(1, 40);
    repeat (2) step();
    chk("drop_done_cyc", 64'(q_at(d_done_q, 0)), 64'(g + 17));
    chk("drop_done_n", 64'(d_done_q.size()), 64'd1);
    compare_plots("drop");

    for (int i = 0; i < 8; i++)
      run_single("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 255),
                 $urandom_range(0, 127), $urandom_range(0, 7));

    chk("dual_done", 64'(dual_done), 64'd0);
    chk("plot_when_idle", 64'(stray_plot), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
